wb_arbiter: RTL
===============

Name: wb_arbiter

Overview:
- Write-back arbiter and scoreboard sitting in front of the integer register file's single write port (addrD/dataD/wEn).
- Merges ALU results, which have no backpressure, with load results, which use a valid/ready handshake, through a small load queue.
- Drives one registered write per cycle.
- Tracks registers with pending writes so issue logic can stall on RAW hazards.

Parameters:
- XLEN, 32, data width of results and write port.
- LQ_DEPTH, 2, load-result queue depth in entries; power of two, >=2.
- NREG, 32, number of architectural registers; register index width is 5.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load result accepted when ld_valid&&ld_ready.
- ld_rd  in  5  load destination register.
- ld_data  in  XLEN  load result.
- iss_valid  in  1  instruction issued with a destination.
- iss_rd  in  5  issued destination; marks the register busy.
- qry_a, qry_b  in  5  source registers being read by decode.
- busy_a, busy_b  out  1  source has a pending write (combinational).
- wb_addr  out  5  register file write address (addrD).
- wb_data  out  XLEN  register file write data (dataD).
- wb_en  out  1  register file write enable (wEn).
- lq_count  out  $clog2(LQ_DEPTH+1)  load queue occupancy.

Behaviour:
- Reset (synchronous, rst high at posedge):
  - wb_en=0, wb_addr=0, wb_data=0.
  - Queue emptied; lq_count=0.
  - Scoreboard all clear.
  - rst has priority over every other event in the same cycle.
- x0 handling:
  - A result with rd==0 is accepted but discarded: no wb_en, no enqueue, no scoreboard change.
  - iss_rd==0 never sets busy.
  - busy for query 0 is always 0.
- Per-cycle selection, priority order:
  - Case 1: alu_valid, rd!=0 → ALU result wins the port.
  - Case 2: otherwise, queue non-empty → write the queue head and pop it.
  - Case 3: otherwise, ld_valid&&ld_ready with queue empty → cut-through; write the load directly and do not enqueue.
  - Case 4: otherwise → wb_en=0 next cycle.
- Write port registers:
  - Loaded at the posedge following selection, giving 1 cycle latency from the result inputs to wb_en.
  - wb_addr/wb_data hold their last value when wb_en=0.
- ld_ready:
  - ld_ready = (lq_count<LQ_DEPTH) || pop this cycle.
  - ld_ready depends only on the queue state and alu_valid, never on ld_valid.
  - An accepted load not written this cycle is enqueued at the tail.
  - Push and pop may occur in the same cycle; lq_count then stays unchanged.
- Queue:
  - Circular buffer; pointer width $clog2(LQ_DEPTH)+1 with wrap bit.
  - full = pointers equal except the MSB.
- Scoreboard (NREG bits):
  - Set at the posedge for iss_rd when iss_valid.
  - Cleared at the posedge where a write to that rd is selected (same edge that loads wb_*).
  - Same-cycle set and clear of the same rd: set wins.
- Busy outputs:
  - busy_a/busy_b = scoreboard[qry].
- Ordering contract:
  - Issue logic never issues a second writer to a busy rd.
  - The bench must honour this contract; the block does not check it.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - Adds outputs byp_hit_a, byp_hit_b (1 bit) and byp_data_a, byp_data_b (XLEN).
  - byp_hit_x = wb_en && wb_addr==qry_x && qry_x!=0.
  - byp_data_x = wb_data.
  - Lets decode consume a value in the cycle it is written.
- Undefined:
  - Ports absent; decode waits one extra cycle after busy clears.

Decomposition:
- Package wb_pkg: XLEN default, REG_IDX_W=5, NREG, and a typedef for the result record {rd, data}.
- Sub-module wb_load_queue: parameterised sync FIFO with push, pop, head, count and full.
- Arbitration, scoreboard and write-port registers stay in wb_arbiter.

Test Plan:
1. Reset then idle, 3 cycles → wb_en=0, lq_count=0, busy_a=busy_b=0 for all qry values.
2. alu_valid, rd=5, data=0xDEADBEEF at cycle N → wb_en=1, wb_addr=5, wb_data=0xDEADBEEF in cycle N+1; wb_en=0 in N+2.
3. Load contention:
   - Stimulus: ALU writes every cycle for 4 cycles; loads to rd 7, 8, 9 offered back to back.
   - Response: rd7 and rd8 are queued; lq_count reaches 2; ld_ready=0 while the queue is full and the ALU holds the port.
   - Response: after the ALU idles, rd7, rd8 and rd9 are written in order, one per cycle.
4. iss rd=3 → busy for qry 3 is 1; load rd=3 accepted cut-through with queue empty → busy clears on the same edge that wb_en rises; a same-cycle re-issue of rd=3 keeps busy=1.
5. alu_valid with rd=0, and a load with rd=0 → no wb_en, lq_count unchanged, ld_ready=1.
6. rst asserted while the queue holds 2 entries and a write is pending → next cycle wb_en=0, lq_count=0, scoreboard clear; the discarded entries are never written.
   - With WB_BYPASS_EN: a write to rd=4 with qry_a=4 gives byp_hit_a=1 and byp_data_a=wb_data.

Source files
------------

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and result record for the write-back arbiter
package wb_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NREG      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_result_t;

endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - synchronous circular FIFO holding load results awaiting the write port
module wb_load_queue #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Extra MSB on each pointer distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - register-file write-port arbiter and RAW scoreboard; WB_BYPASS_EN adds decode bypass outputs
module wb_arbiter #(
    parameter int XLEN     = wb_pkg::XLEN,
    parameter int LQ_DEPTH = 2,
    parameter int NREG     = wb_pkg::NREG
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            alu_valid,
    input  logic [wb_pkg::REG_IDX_W-1:0]    alu_rd,
    input  logic [XLEN-1:0]                 alu_data,
    input  logic                            ld_valid,
    output logic                            ld_ready,
    input  logic [wb_pkg::REG_IDX_W-1:0]    ld_rd,
    input  logic [XLEN-1:0]                 ld_data,
    input  logic                            iss_valid,
    input  logic [wb_pkg::REG_IDX_W-1:0]    iss_rd,
    input  logic [wb_pkg::REG_IDX_W-1:0]    qry_a,
    input  logic [wb_pkg::REG_IDX_W-1:0]    qry_b,
    output logic                            busy_a,
    output logic                            busy_b,
    output logic [wb_pkg::REG_IDX_W-1:0]    wb_addr,
    output logic [XLEN-1:0]                 wb_data,
    output logic                            wb_en,
`ifdef WB_BYPASS_EN
    output logic                            byp_hit_a,
    output logic                            byp_hit_b,
    output logic [XLEN-1:0]                 byp_data_a,
    output logic [XLEN-1:0]                 byp_data_b,
`endif
    output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count
);

    import wb_pkg::*;

    localparam int ENTRY_W = REG_IDX_W + XLEN;

    logic                 alu_sel;
    logic                 ld_acc;
    logic                 cut;
    logic                 push;
    logic                 pop;
    logic                 q_full;
    logic                 q_empty;
    logic [ENTRY_W-1:0]   q_head;
    logic                 sel_valid;
    logic [REG_IDX_W-1:0] sel_rd;
    logic [XLEN-1:0]      sel_data;
    logic [NREG-1:0]      sb;
    logic [NREG-1:0]      sb_next;

    // Results to x0 are swallowed here so they never reach the port, queue or scoreboard.
    assign alu_sel  = alu_valid && (alu_rd != '0);
    assign pop      = !alu_sel && !q_empty;
    assign ld_ready = !q_full || pop;
    assign ld_acc   = ld_valid && ld_ready && (ld_rd != '0);
    assign cut      = ld_acc && !alu_sel && q_empty;
    assign push     = ld_acc && !cut;

    wb_load_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (LQ_DEPTH)
    ) u_lq (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({ld_rd, ld_data}),
        .pop       (pop),
        .head      (q_head),
        .count     (lq_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = alu_rd;
        sel_data  = alu_data;
        if (alu_sel) begin
            sel_valid = 1'b1;
        end else if (!q_empty) begin
            sel_valid = 1'b1;
            sel_rd    = q_head[ENTRY_W-1:XLEN];
            sel_data  = q_head[XLEN-1:0];
        end else if (cut) begin
            sel_valid = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end
    end

    // Set is applied after clear so a same-cycle re-issue keeps the register busy.
    always_comb begin
        sb_next = sb;
        if (sel_valid) begin
            sb_next[sel_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            sb_next[iss_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_en   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            sb      <= '0;
        end else begin
            wb_en <= sel_valid;
            if (sel_valid) begin
                wb_addr <= sel_rd;
                wb_data <= sel_data;
            end
            sb <= sb_next;
        end
    end

    assign busy_a = (qry_a != '0) && sb[qry_a];
    assign busy_b = (qry_b != '0) && sb[qry_b];

`ifdef WB_BYPASS_EN
    assign byp_hit_a  = wb_en && (wb_addr == qry_a) && (qry_a != '0);
    assign byp_hit_b  = wb_en && (wb_addr == qry_b) && (qry_b != '0);
    assign byp_data_a = wb_data;
    assign byp_data_b = wb_data;
`endif

endmodule
